// File: rtl/aap_fetch_pkg.sv
// Shared definitions for the AAP instruction fetch unit.
//   ADDR_W       word-address width of instruction memory
//   WORD_W       instruction memory word width
//   INSN_W       width of an assembled instruction (two words)
//   LEN_BIT      bit of the first word that selects 16-bit vs 32-bit length
//   QUEUE_DEPTH  prefetch queue entries (power of two, >= 2)
//   LEVEL_W      width of the queue occupancy count (0..QUEUE_DEPTH)
//   fetch_entry_t  one prefetched word with the address it was read from
package aap_fetch_pkg;

  localparam int unsigned ADDR_W      = 20;
  localparam int unsigned WORD_W      = 16;
  localparam int unsigned INSN_W      = 32;
  localparam int unsigned LEN_BIT     = 15;
  localparam int unsigned QUEUE_DEPTH = 4;
  localparam int unsigned LEVEL_W     = 3;

  typedef struct packed {
    logic [WORD_W-1:0] word;
    logic [ADDR_W-1:0] addr;
  } fetch_entry_t;

  // High length bit marks the first word of a 32-bit instruction.
  function automatic logic is_long_insn(input logic [WORD_W-1:0] word);
    return word[LEN_BIT];
  endfunction

endpackage : aap_fetch_pkg

// File: rtl/instruction_fetch_unit_if.sv
// Bus bundle between the fetch unit, instruction memory, execute and decode.
//   imem_addr/imem_data/fetch_req      instruction memory read port
//   redirect_valid/redirect_pc         branch redirect from execute
//   insn_valid/insn_ready/insn_out/
//   insn_len/insn_pc                   instruction handshake to decode
//   queue_level                        prefetch queue occupancy
// master: the fetch unit; slave: the surrounding pipeline/memory.
interface instruction_fetch_unit_if;
  import aap_fetch_pkg::*;

  logic [ADDR_W-1:0]  imem_addr;
  logic [WORD_W-1:0]  imem_data;
  logic               fetch_req;
  logic               redirect_valid;
  logic [ADDR_W-1:0]  redirect_pc;
  logic               insn_valid;
  logic               insn_ready;
  logic [INSN_W-1:0]  insn_out;
  logic               insn_len;
  logic [ADDR_W-1:0]  insn_pc;
  logic [LEVEL_W-1:0] queue_level;

  modport master (
    output imem_addr,
    input  imem_data,
    output fetch_req,
    input  redirect_valid,
    input  redirect_pc,
    output insn_valid,
    input  insn_ready,
    output insn_out,
    output insn_len,
    output insn_pc,
    output queue_level
  );

  modport slave (
    input  imem_addr,
    output imem_data,
    input  fetch_req,
    output redirect_valid,
    output redirect_pc,
    input  insn_valid,
    output insn_ready,
    input  insn_out,
    input  insn_len,
    input  insn_pc,
    input  queue_level
  );

endinterface : instruction_fetch_unit_if

// File: rtl/fetch_queue.sv
// Prefetch FIFO of fetch_entry_t: one push per cycle, pop of 0/1/2 entries,
// flush empties the queue. Exposes occupancy plus the head and head+1 entries
// so the top level can assemble a 32-bit instruction in one cycle.
//   clock, reset     rising-edge clock, synchronous active-high reset
//   flush_i          discard all entries (takes priority over push/pop)
//   push_i           write push_entry_i at the tail
//   pop_cnt_i        number of entries retired from the head (0..2)
//   count_o          occupancy at the start of the cycle
//   head_o, head1_o  oldest and second-oldest entries
module fetch_queue
  import aap_fetch_pkg::*;
#(
  parameter int unsigned DEPTH = QUEUE_DEPTH
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               flush_i,
  input  logic               push_i,
  input  fetch_entry_t       push_entry_i,
  input  logic [1:0]         pop_cnt_i,
  output logic [LEVEL_W-1:0] count_o,
  output fetch_entry_t       head_o,
  output fetch_entry_t       head1_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  fetch_entry_t       mem_q [DEPTH];
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [LEVEL_W-1:0] count_q, count_d;
  logic               wr_en;

  assign wr_en = push_i && !flush_i;

  // Pointer/occupancy update; pointers wrap naturally at the power-of-two depth.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_i) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      rd_ptr_d = rd_ptr_q + PTR_W'(pop_cnt_i);
      count_d  = count_q + LEVEL_W'(push_i) - LEVEL_W'(pop_cnt_i);
    end
  end

  // Control state
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents are only meaningful below count_q, so no reset.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= push_entry_i;
    end
  end

  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];
  assign head1_o = mem_q[rd_ptr_q + PTR_W'(1)];

`ifndef SYNTHESIS
  // Producer must never overfill or overdrain the queue.
  always_ff @(posedge clock) begin
    if (!reset && !flush_i) begin
      assert (!(push_i && count_q == LEVEL_W'(DEPTH)))
        else $error("fetch_queue push while full");
      assert (LEVEL_W'(pop_cnt_i) <= count_q)
        else $error("fetch_queue pop beyond occupancy");
    end
  end
`endif

endmodule : fetch_queue

// File: rtl/instruction_fetch_unit.sv
// AAP instruction fetch unit: drives the combinational instruction memory
// read port, prefetches words into a small queue, and assembles 16-bit or
// 32-bit instructions for decode over a valid/ready handshake. Execute may
// redirect fetch at any time, which flushes everything in flight.
//   clock, reset  rising-edge clock, synchronous active-high reset
//   bus           instruction_fetch_unit_if.master (memory port, redirect,
//                 decode handshake, queue occupancy)
module instruction_fetch_unit
  import aap_fetch_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                     clock,
  input  logic                     reset,
  instruction_fetch_unit_if.master bus
);

  logic [ADDR_W-1:0]  fetch_pc_q, fetch_pc_d;
  logic [LEVEL_W-1:0] count;
  fetch_entry_t       head;
  fetch_entry_t       head1;
  fetch_entry_t       push_entry;
  logic               push;
  logic [1:0]         pop_cnt;
  logic               head_long;
  logic               insn_avail;
  logic               handshake;
  logic               unused_head1_addr;

  // Fetch whenever a slot is free at the start of the cycle; a same-cycle pop
  // is deliberately not counted, keeping the memory request off the ready path.
  assign push = !reset && !bus.redirect_valid && (count < LEVEL_W'(QUEUE_DEPTH));

  assign push_entry.word = bus.imem_data;
  assign push_entry.addr = fetch_pc_q;

  fetch_queue #(
    .DEPTH (QUEUE_DEPTH)
  ) u_queue (
    .clock        (clock),
    .reset        (reset),
    .flush_i      (bus.redirect_valid),
    .push_i       (push),
    .push_entry_i (push_entry),
    .pop_cnt_i    (pop_cnt),
    .count_o      (count),
    .head_o       (head),
    .head1_o      (head1)
  );

  // Second word's address is implied by insn_pc + 1.
  assign unused_head1_addr = ^head1.addr;

  // Length decode and decode-side handshake
  always_comb begin
    head_long      = is_long_insn(head.word);
    insn_avail     = 1'b0;
    handshake      = 1'b0;
    pop_cnt        = 2'd0;
    bus.insn_valid = 1'b0;
    bus.insn_out   = '0;
    bus.insn_len   = 1'b0;
    bus.insn_pc    = '0;

    if (!bus.redirect_valid) begin
      insn_avail = head_long ? (count >= LEVEL_W'(2)) : (count >= LEVEL_W'(1));
    end

    if (insn_avail) begin
      bus.insn_valid = 1'b1;
      bus.insn_len   = head_long;
      bus.insn_pc    = head.addr;
      bus.insn_out   = head_long ? {head1.word, head.word}
                                 : {WORD_W'(0), head.word};
      handshake      = bus.insn_ready;
      if (handshake) begin
        pop_cnt = head_long ? 2'd2 : 2'd1;
      end
    end
  end

  // Next fetch address; redirect wins, otherwise advance (mod 2^ADDR_W) per fetch.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    if (bus.redirect_valid) begin
      fetch_pc_d = bus.redirect_pc;
    end else if (push) begin
      fetch_pc_d = fetch_pc_q + ADDR_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      fetch_pc_q <= RESET_PC;
    end else begin
      fetch_pc_q <= fetch_pc_d;
    end
  end

  assign bus.imem_addr   = fetch_pc_q;
  assign bus.fetch_req   = push;
  assign bus.queue_level = count;

endmodule : instruction_fetch_unit

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit. Inputs are driven and outputs
// checked just after the falling edge, well away from the rising edge.
module tb_instruction_fetch_unit;
  import aap_fetch_pkg::*;

  logic clock = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_errors = 0;

  logic [15:0] mem [512];

  always #5 clock = ~clock;

  instruction_fetch_unit_if bus ();

  instruction_fetch_unit #(
    .RESET_PC (20'h00000)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.master)
  );

  // Memory model: low 9 address bits, so 20'hFFFFF aliases to entry 9'h1FF.
  assign bus.imem_data = mem[bus.imem_addr[8:0]];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
    #1;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 512; i++) mem[i] = 16'h0000;
  endtask

  task automatic release_reset();
    reset = 1'b1;
    bus.redirect_valid = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    #1;
  endtask

  initial begin
    reset              = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.insn_ready     = 1'b1;

    // ---- reset values, then four back-to-back 16-bit instructions ----
    clear_mem();
    for (int i = 0; i < 4; i++) mem[i] = 16'(i + 1);
    tick();
    tick();
    chk("rst_fetch_req", 32'(bus.fetch_req), 32'd0);
    chk("rst_imem_addr", 32'(bus.imem_addr), 32'd0);
    chk("rst_level",     32'(bus.queue_level), 32'd0);
    chk("rst_valid",     32'(bus.insn_valid), 32'd0);
    chk("rst_out",       bus.insn_out, 32'd0);
    chk("rst_len",       32'(bus.insn_len), 32'd0);
    chk("rst_pc",        32'(bus.insn_pc), 32'd0);
    reset = 1'b0;
    #1;
    chk("first_fetch_req", 32'(bus.fetch_req), 32'd1);
    chk("first_imem_addr", 32'(bus.imem_addr), 32'd0);
    chk("first_valid",     32'(bus.insn_valid), 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("s16_valid", 32'(bus.insn_valid), 32'd1);
      chk("s16_pc",    32'(bus.insn_pc), 32'(i));
      chk("s16_out",   bus.insn_out, 32'(i + 1));
      chk("s16_len",   32'(bus.insn_len), 32'd0);
    end

    // ---- one 32-bit instruction followed by a 16-bit one ----
    clear_mem();
    mem[0] = 16'h8123;
    mem[1] = 16'h4567;
    mem[2] = 16'h0005;
    mem[3] = 16'h0006;
    release_reset();
    tick();
    chk("l32_half_valid", 32'(bus.insn_valid), 32'd0);
    chk("l32_half_level", 32'(bus.queue_level), 32'd1);
    tick();
    chk("l32_valid", 32'(bus.insn_valid), 32'd1);
    chk("l32_out",   bus.insn_out, 32'h4567_8123);
    chk("l32_len",   32'(bus.insn_len), 32'd1);
    chk("l32_pc",    32'(bus.insn_pc), 32'd0);
    tick();
    chk("l32_next_pc",  32'(bus.insn_pc), 32'd2);
    chk("l32_next_out", bus.insn_out, 32'h0000_0005);
    chk("l32_next_len", 32'(bus.insn_len), 32'd0);

    // ---- stall: queue saturates, outputs hold, resume in order ----
    clear_mem();
    for (int i = 0; i < 8; i++) mem[i] = 16'(16'h0010 + i);
    bus.insn_ready = 1'b0;
    release_reset();
    for (int c = 0; c < 10; c++) begin
      tick();
      chk("stall_valid", 32'(bus.insn_valid), 32'd1);
      chk("stall_pc",    32'(bus.insn_pc), 32'd0);
      chk("stall_out",   bus.insn_out, 32'h0000_0010);
    end
    chk("stall_level",     32'(bus.queue_level), 32'd4);
    chk("stall_fetch_req", 32'(bus.fetch_req), 32'd0);
    chk("stall_imem_addr", 32'(bus.imem_addr), 32'd4);
    bus.insn_ready = 1'b1;
    #1;
    for (int i = 0; i < 8; i++) begin
      chk("resume_pc",  32'(bus.insn_pc), 32'(i));
      chk("resume_out", bus.insn_out, 32'(16'h0010 + i));
      tick();
    end

    // ---- redirect with three entries queued ----
    clear_mem();
    for (int i = 0; i < 8; i++) mem[i] = 16'(16'h0020 + i);
    mem[9'h100] = 16'h0777;
    bus.insn_ready = 1'b0;
    release_reset();
    tick();
    tick();
    tick();
    chk("pre_redir_level", 32'(bus.queue_level), 32'd3);
    chk("pre_redir_valid", 32'(bus.insn_valid), 32'd1);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 20'h00100;
    #1;
    chk("redir_valid",     32'(bus.insn_valid), 32'd0);
    chk("redir_fetch_req", 32'(bus.fetch_req), 32'd0);
    chk("redir_out",       bus.insn_out, 32'd0);
    tick();
    bus.redirect_valid = 1'b0;
    bus.insn_ready     = 1'b1;
    #1;
    chk("post_redir_level", 32'(bus.queue_level), 32'd0);
    chk("post_redir_addr",  32'(bus.imem_addr), 32'h00100);
    chk("post_redir_req",   32'(bus.fetch_req), 32'd1);
    chk("post_redir_valid", 32'(bus.insn_valid), 32'd0);
    tick();
    chk("redir_insn_valid", 32'(bus.insn_valid), 32'd1);
    chk("redir_insn_pc",    32'(bus.insn_pc), 32'h00100);
    chk("redir_insn_out",   bus.insn_out, 32'h0000_0777);

    // ---- 32-bit instruction straddling the address wrap ----
    mem[9'h1FF] = 16'h8AAA;
    mem[0]      = 16'h0BBB;
    mem[1]      = 16'h0CCC;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 20'hFFFFF;
    #1;
    tick();
    bus.redirect_valid = 1'b0;
    #1;
    chk("wrap_addr0",  32'(bus.imem_addr), 32'h000FFFFF);
    chk("wrap_level0", 32'(bus.queue_level), 32'd0);
    tick();
    chk("wrap_half_valid", 32'(bus.insn_valid), 32'd0);
    chk("wrap_addr1",      32'(bus.imem_addr), 32'h00000);
    tick();
    chk("wrap_valid", 32'(bus.insn_valid), 32'd1);
    chk("wrap_out",   bus.insn_out, 32'h0BBB_8AAA);
    chk("wrap_pc",    32'(bus.insn_pc), 32'h000FFFFF);
    chk("wrap_len",   32'(bus.insn_len), 32'd1);
    chk("wrap_addr2", 32'(bus.imem_addr), 32'h00001);

    // ---- reset during half-assembled 32-bit instruction ----
    clear_mem();
    mem[9'h040] = 16'h8001;
    mem[9'h041] = 16'h1234;
    mem[0]      = 16'h0003;
    release_reset();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 20'h00040;
    #1;
    tick();
    bus.redirect_valid = 1'b0;
    #1;
    tick();
    chk("mid_level", 32'(bus.queue_level), 32'd1);
    chk("mid_valid", 32'(bus.insn_valid), 32'd0);
    chk("mid_addr",  32'(bus.imem_addr), 32'h00041);
    reset = 1'b1;
    #1;
    chk("mid_rst_req", 32'(bus.fetch_req), 32'd0);
    tick();
    chk("mid_rst_level", 32'(bus.queue_level), 32'd0);
    chk("mid_rst_valid", 32'(bus.insn_valid), 32'd0);
    chk("mid_rst_out",   bus.insn_out, 32'd0);
    chk("mid_rst_len",   32'(bus.insn_len), 32'd0);
    chk("mid_rst_pc",    32'(bus.insn_pc), 32'd0);
    chk("mid_rst_addr",  32'(bus.imem_addr), 32'd0);
    reset = 1'b0;
    #1;
    chk("restart_req",  32'(bus.fetch_req), 32'd1);
    chk("restart_addr", 32'(bus.imem_addr), 32'd0);
    tick();
    chk("restart_valid", 32'(bus.insn_valid), 32'd1);
    chk("restart_pc",    32'(bus.insn_pc), 32'd0);
    chk("restart_out",   bus.insn_out, 32'h0000_0003);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_instruction_fetch_unit
